// File: rtl/id_ex_stage_reg_if.sv
// ID/EX pipeline-register bus: decode-side fields and flush in, EX-side fields and stall out.
// The master drives ID fields (decoder + hazard unit side); the slave is the register itself.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic              id_reg_dst, id_branch, id_mem_read, id_mem_to_reg;
    logic              id_mem_write, id_alu_src, id_reg_write;
    logic [1:0]        id_alu_op;
    logic [DATA_W-1:0] id_pc_plus4, id_rd1, id_rd2, id_imm;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic [5:0]        id_funct;
    logic              flush;

    logic              ex_valid;
    logic              ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic              ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_imm;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_dst;
    logic [5:0]        ex_funct;
    logic              stall;

    modport master (
        output id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_alu_op,
               id_pc_plus4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct, flush,
        input  ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
               ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
               ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_dst, ex_funct, stall
    );

    modport slave (
        input  id_valid, id_reg_dst, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_alu_op,
               id_pc_plus4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct, flush,
        output ex_valid, ex_reg_dst, ex_branch, ex_mem_read, ex_mem_to_reg,
               ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
               ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_dst, ex_funct, stall
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard/flush/idle, and saturating stall and flush event counters.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_stage_reg_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef struct packed {
        logic              valid;
        logic              reg_dst, branch, mem_read, mem_to_reg;
        logic              mem_write, alu_src, reg_write;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] pc_plus4, rd1, rd2, imm;
        logic [REG_AW-1:0] rs, rt, dst;
        logic [5:0]        funct;
    } ex_t;

    ex_t  ex_q, ex_d;
    logic uses_rt, hazard, load;

    // Hazard looks at the instruction currently in EX, so a bubble clears it next cycle.
    always_comb begin
        uses_rt = !bus.id_alu_src | bus.id_mem_write;
        hazard  = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rt != '0) &
                  ((ex_q.rt == bus.id_rs) | (uses_rt & (ex_q.rt == bus.id_rt)));
        load    = bus.id_valid & !bus.flush & !hazard;
    end

    assign bus.stall = hazard & !bus.flush;

    always_comb begin
        ex_d = '0;
        if (load) begin
            ex_d.valid      = 1'b1;
            ex_d.reg_dst    = bus.id_reg_dst;
            ex_d.branch     = bus.id_branch;
            ex_d.mem_read   = bus.id_mem_read;
            ex_d.mem_to_reg = bus.id_mem_to_reg;
            ex_d.mem_write  = bus.id_mem_write;
            ex_d.alu_src    = bus.id_alu_src;
            ex_d.reg_write  = bus.id_reg_write;
            ex_d.alu_op     = bus.id_alu_op;
            ex_d.pc_plus4   = bus.id_pc_plus4;
            ex_d.rd1        = bus.id_rd1;
            ex_d.rd2        = bus.id_rd2;
            ex_d.imm        = bus.id_imm;
            ex_d.rs         = bus.id_rs;
            ex_d.rt         = bus.id_rt;
            ex_d.dst        = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
            ex_d.funct      = bus.id_funct;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.stall && !(&stall_cnt))                  stall_cnt <= stall_cnt + 1'b1;
            if (bus.flush && bus.id_valid && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_reg_dst    = ex_q.reg_dst;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_pc_plus4   = ex_q.pc_plus4;
    assign bus.ex_rd1        = ex_q.rd1;
    assign bus.ex_rd2        = ex_q.rd2;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_dst        = ex_q.dst;
    assign bus.ex_funct      = ex_q.funct;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomized and directed bench for id_ex_stage_reg against an instruction-level model.
module tb_id_ex_stage_reg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic          valid, reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
        logic [1:0]    alu_op;
        logic [DW-1:0] pc4, rd1, rd2, imm;
        logic [AW-1:0] rs, rt, dst;
        logic [5:0]    funct;
    } exv_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CW-1:0] stall_cnt, flush_cnt;
    int checks = 0;
    int failures = 0;

    id_ex_stage_reg_if #(.DATA_W(DW), .REG_AW(AW)) b ();
    id_ex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    always #5 clk = ~clk;

    // Model: what EX holds, in instruction terms, plus event tallies.
    exv_t m_ex;
    int   m_scnt, m_fcnt;

    function automatic bit m_hazard();
        bit src_rs, src_rt;
        if (!(b.id_valid && m_ex.valid && m_ex.mem_read && m_ex.rt != 0)) return 0;
        src_rs = (m_ex.rt == b.id_rs);
        // rt is read by R-types/branches (register operand) and by stores (data)
        src_rt = (!b.id_alu_src || b.id_mem_write) && (m_ex.rt == b.id_rt);
        return src_rs || src_rt;
    endfunction

    function automatic bit m_stall();
        return m_hazard() && !b.flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex = '0; m_scnt = 0; m_fcnt = 0;
        end else begin
            bit hz;
            hz = m_hazard();
            if (hz && !b.flush) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
            if (b.flush && b.id_valid) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
            m_ex = '0;
            if (b.id_valid && !b.flush && !hz) begin
                m_ex.valid = 1; m_ex.reg_dst = b.id_reg_dst; m_ex.branch = b.id_branch;
                m_ex.mem_read = b.id_mem_read; m_ex.mem_to_reg = b.id_mem_to_reg;
                m_ex.mem_write = b.id_mem_write; m_ex.alu_src = b.id_alu_src;
                m_ex.reg_write = b.id_reg_write; m_ex.alu_op = b.id_alu_op;
                m_ex.pc4 = b.id_pc_plus4; m_ex.rd1 = b.id_rd1; m_ex.rd2 = b.id_rd2;
                m_ex.imm = b.id_imm; m_ex.rs = b.id_rs; m_ex.rt = b.id_rt;
                m_ex.dst = b.id_reg_dst ? b.id_rd : b.id_rt; m_ex.funct = b.id_funct;
            end
        end
    end

    function automatic exv_t dut_ex();
        exv_t e;
        e = {b.ex_valid, b.ex_reg_dst, b.ex_branch, b.ex_mem_read, b.ex_mem_to_reg,
             b.ex_mem_write, b.ex_alu_src, b.ex_reg_write, b.ex_alu_op, b.ex_pc_plus4,
             b.ex_rd1, b.ex_rd2, b.ex_imm, b.ex_rs, b.ex_rt, b.ex_dst, b.ex_funct};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic clr_id();
        b.id_valid = 0; b.id_reg_dst = 0; b.id_branch = 0; b.id_mem_read = 0;
        b.id_mem_to_reg = 0; b.id_mem_write = 0; b.id_alu_src = 0; b.id_reg_write = 0;
        b.id_alu_op = 0; b.id_pc_plus4 = 0; b.id_rd1 = 0; b.id_rd2 = 0; b.id_imm = 0;
        b.id_rs = 0; b.id_rt = 0; b.id_rd = 0; b.id_funct = 0; b.flush = 0;
    endtask

    task automatic set_rtype(input int rs, input int rt, input int rd, input int v1, input int v2);
        clr_id();
        b.id_valid = 1; b.id_reg_dst = 1; b.id_alu_op = 2'b10; b.id_reg_write = 1;
        b.id_rs = rs[AW-1:0]; b.id_rt = rt[AW-1:0]; b.id_rd = rd[AW-1:0];
        b.id_rd1 = v1; b.id_rd2 = v2; b.id_funct = 6'h20; b.id_pc_plus4 = 32'h104;
    endtask

    task automatic set_lw(input int rs, input int rt);
        clr_id();
        b.id_valid = 1; b.id_mem_read = 1; b.id_mem_to_reg = 1; b.id_alu_src = 1;
        b.id_reg_write = 1; b.id_rs = rs[AW-1:0]; b.id_rt = rt[AW-1:0]; b.id_imm = 32'h8;
    endtask

    task automatic set_addi(input int rs, input int rt);
        clr_id();
        b.id_valid = 1; b.id_alu_src = 1; b.id_reg_write = 1;
        b.id_rs = rs[AW-1:0]; b.id_rt = rt[AW-1:0]; b.id_imm = 32'h5;
    endtask

    task automatic set_rand();
        b.id_valid = ($urandom_range(0, 7) != 0);
        {b.id_reg_dst, b.id_branch, b.id_mem_to_reg, b.id_mem_write, b.id_alu_src, b.id_reg_write} = 6'($urandom);
        b.id_mem_read = $urandom_range(0, 1); b.id_alu_op = 2'($urandom);
        b.id_pc_plus4 = $urandom; b.id_rd1 = $urandom; b.id_rd2 = $urandom; b.id_imm = $urandom;
        b.id_rs = AW'($urandom_range(0, 3)); b.id_rt = AW'($urandom_range(0, 3));
        b.id_rd = AW'($urandom_range(0, 31)); b.id_funct = 6'($urandom);
        b.flush = ($urandom_range(0, 7) == 0);
    endtask

    // Inputs are set around the falling edge; stall is checked before the rising edge,
    // registered outputs and counters just after it.
    task automatic cyc();
        #1 chk("stall", 256'(b.stall), 256'(m_stall()));
        @(posedge clk); #1;
        chk("ex_fields", 256'(dut_ex()), 256'(m_ex));
        chk("stall_cnt", 256'(stall_cnt), 256'(m_scnt));
        chk("flush_cnt", 256'(flush_cnt), 256'(m_fcnt));
        @(negedge clk);
    endtask

    initial begin
        clr_id();
        #12;
        chk("reset_ex", 256'(dut_ex()), 256'(0));
        chk("reset_cnt", 256'({stall_cnt, flush_cnt}), 256'(0));
        @(negedge clk); rst_n = 1;

        // R-type add
        set_rtype(8, 9, 10, 'h11, 'h22);
        #1 chk("add_stall", 256'(b.stall), 256'(0));
        cyc();
        chk("add_valid", 256'(b.ex_valid), 256'(1));
        chk("add_dst", 256'(b.ex_dst), 256'(10));
        chk("add_aluop", 256'(b.ex_alu_op), 256'(2));
        chk("add_rd1_rd2", 256'({b.ex_rd1, b.ex_rd2}), {192'd0, 32'h11, 32'h22});

        // load-use: lw $9 then add using $9
        set_lw(1, 9); cyc();
        set_rtype(9, 3, 4, 'h5, 'h6);
        #1 chk("lu_stall", 256'(b.stall), 256'(1));
        cyc();
        chk("lu_bubble", 256'(dut_ex()), 256'(0));
        chk("lu_scnt", 256'(stall_cnt), 256'(1));
        #1 chk("lu_release", 256'(b.stall), 256'(0));
        cyc();
        chk("lu_captured", 256'({b.ex_valid, b.ex_rs, b.ex_dst}), 256'({1'b1, 5'd9, 5'd4}));

        // addi writes rt: no stall; lw $0: no stall
        set_lw(1, 9); cyc();
        set_addi(2, 9);
        #1 chk("addi_nostall", 256'(b.stall), 256'(0));
        cyc();
        set_lw(1, 0); cyc();
        set_rtype(0, 0, 5, 1, 2);
        #1 chk("zero_nostall", 256'(b.stall), 256'(0));
        cyc();

        // flush overriding a hazard
        set_lw(1, 9); cyc();
        set_rtype(9, 9, 4, 1, 2); b.flush = 1;
        #1 chk("flush_nostall", 256'(b.stall), 256'(0));
        cyc();
        chk("flush_bubble", 256'(b.ex_valid), 256'(0));
        chk("flush_cnts", 256'({stall_cnt, flush_cnt}), 256'({8'd1, 8'd1}));

        // async reset between edges
        set_rtype(3, 4, 6, 7, 8); cyc();
        #2 rst_n = 0;
        #1 chk("arst_ex", 256'(dut_ex()), 256'(0));
        chk("arst_cnt", 256'({stall_cnt, flush_cnt}), 256'(0));
        #1 rst_n = 1;
        @(negedge clk);
        set_rtype(3, 4, 6, 7, 8); cyc();
        chk("post_rst_valid", 256'({b.ex_valid, b.ex_dst}), 256'({1'b1, 5'd6}));

        for (int i = 0; i < 2000; i++) begin
            set_rand(); cyc();
        end

        // drive the stall counter past saturation
        for (int i = 0; i < CMAX + 40; i++) begin
            set_lw(1, 9); cyc();
            set_rtype(9, 2, 3, 0, 0); cyc();
        end
        chk("scnt_sat", 256'(stall_cnt), 256'(CMAX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Captures the main control decoder outputs (RegDst, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite) together with the decode-stage operands, and presents them to EX one cycle later.
- Contains the load-use hazard detector. On a hazard it stalls PC and IF/ID and inserts a bubble.
- Accepts a flush from EX on a taken branch. Keeps saturating stall and flush performance counters.

Parameters:
- DATA_W, 32, width of operand, immediate and PC+4 fields
- REG_AW, 5, register-specifier width
- CNT_W, 16, performance counter width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- id_valid  input  1  the ID stage holds a real instruction
- id_reg_dst, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  input  1 each  decoder control outputs
- id_alu_op  input  2  decoder ALUOp
- id_pc_plus4, id_rd1, id_rd2, id_imm  input  DATA_W each  PC+4, register reads, sign-extended immediate
- id_rs, id_rt, id_rd  input  REG_AW each  register specifiers
- id_funct  input  6  instruction funct field
- flush  input  1  taken branch resolved in EX; squash the ID instruction
- ex_valid  output  1  the EX stage holds a real instruction
- ex_reg_dst … ex_reg_write, ex_alu_op  output  (same widths as inputs)  registered control
- ex_pc_plus4, ex_rd1, ex_rd2, ex_imm  output  DATA_W  registered data
- ex_rs, ex_rt, ex_dst  output  REG_AW  registered rs, rt, and destination register (id_reg_dst ? id_rd : id_rt)
- ex_funct  output  6  registered funct
- stall  output  1  combinational; hold PC and IF/ID this cycle
- stall_cnt, flush_cnt  output  CNT_W  saturating event counters

Behaviour:
- Clock and reset: single clk. rst_n is asynchronous and active-low. While rst_n is low, every registered output and counter is 0 and ex_valid is 0.
- Hazard detection (combinational, from current inputs and current EX registers):
  - uses_rt = !id_alu_src | id_mem_write
  - hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)))
  - stall = hazard & !flush
- Per-edge update, in priority order:
  - flush: load a bubble.
  - else hazard: load a bubble.
  - else id_valid: capture all id_* fields, set ex_valid = 1.
  - else (!id_valid): load a bubble.
- Bubble contents: every control output 0, ex_valid 0, and all data/specifier fields 0. No stale data is carried into EX.
- Latency: exactly 1 cycle from ID inputs to EX outputs. There is no internal buffering beyond this single register.
- Stall duration: a single load-use stall lasts exactly one cycle. The bubble clears ex_mem_read, so the hazard deasserts on the next cycle with the same ID instruction.
- Flush precedence:
  - flush overrides hazard, and stall stays 0, so fetch can redirect.
  - flush with id_valid = 0 still loads a bubble.
  - flush_cnt increments only when id_valid = 1, i.e. a real instruction was squashed.
- stall_cnt increments on every edge where stall = 1.
- Counter width and saturation: both counters saturate at 2^CNT_W − 1 and do not wrap.
- $zero rule: a load whose destination is $zero (ex_rt = 0) never causes a stall.
- Mid-operation reset: asserting rst_n low clears the pipeline register and both counters immediately, with no clock edge required. The first edge after release captures normally.

Test Plan:
- R-type add: id_valid = 1, rs = 8, rt = 9, rd = 10, decoder R-type values (reg_dst = 1, alu_op = 10, reg_write = 1), rd1 = 0x11, rd2 = 0x22 → one edge later ex_valid = 1, ex_dst = 10, ex_alu_op = 10, ex_rd1 = 0x11, ex_rd2 = 0x22; stall stays 0.
- Load-use hazard: `lw $9` in EX (ex_mem_read = 1, ex_rt = 9), then `add rs = 9` in ID → stall = 1 that cycle. Next edge: ex_valid = 0, all control 0, stall_cnt = 1. Following cycle: stall = 0 and the add is captured.
- No false stalls:
  - `lw $9` followed by `addi` with rt = 9 (alu_src = 1, rt is a destination, not a source) → stall = 0.
  - `lw $0` followed by a use of rs = 0 → stall = 0.
- Flush during hazard: hazard conditions true and flush = 1 → stall = 0. Next edge: bubble loaded, flush_cnt = 1, stall_cnt unchanged.
- Counter saturation: force 2^16 + 5 stall cycles → stall_cnt holds at 0xFFFF.
- Async reset mid-stream: rst_n low between clock edges while ex_valid = 1 and counters are nonzero → all outputs 0 immediately. After release, the next valid instruction appears one edge later.
